user_port: RTL and testbench

Board-side I/O peripheral that sits at the other end of the CPU's `x` / `readyin` / `outport` interface. It synchronises and debounces the user key and switch bank, latches the operand onto `x`, and drives `readyin` as the debounced key level that the program polls with branch instructions. It also captures every change on the CPU's `outport` into a display register with a one-cycle strobe.

---
 rtl/io_pkg.sv | 5 +
 rtl/sync2.sv | 20 ++
 rtl/user_port.sv | 88 ++++++++
 tb/tb_user_port.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared types and defaults for the user I/O port.
package io_pkg;
    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} db_state_t;
    localparam int DB_CYCLES_DEF = 50000;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for asynchronous inputs.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/user_port.sv
// user_port: debounced key/switch front end for the CPU, plus an outport capture register.
module user_port
    import io_pkg::*;
#(
    parameter int n         = 8,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] sw,
    input  logic         key,
    input  logic [n-1:0] outport,
    output logic [n-1:0] x,
    output logic         readyin,
    output logic [n-1:0] disp,
    output logic         new_result,
    output logic [3:0]   press_count
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    // The IDLE/HELD sample counts as the first stable cycle, so debounce states end one short.
    localparam bit FAST = (DB_CYCLES == 1);
    localparam logic [CW-1:0] LAST = CW'(FAST ? 0 : DB_CYCLES - 2);

    logic         key_s;
    logic [n-1:0] sw_s;
    logic [n-1:0] cap;
    logic [CW-1:0] cnt;
    db_state_t    state;

    sync2 #(.W(1)) u_key_sync (.clk(clk), .reset(reset), .d(key), .q(key_s));
    sync2 #(.W(n)) u_sw_sync  (.clk(clk), .reset(reset), .d(sw),  .q(sw_s));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            readyin     <= 1'b0;
            x           <= '0;
            press_count <= '0;
        end else begin
            cnt <= '0;
            case (state)
                IDLE: if (key_s) begin
                    state   <= FAST ? HELD : PRESS_DB;
                    readyin <= FAST;
                    if (FAST) begin
                        x           <= sw_s;
                        press_count <= press_count + 4'd1;
                    end
                end
                PRESS_DB: if (!key_s) begin
                    state <= IDLE;
                end else if (cnt == LAST) begin
                    state       <= HELD;
                    readyin     <= 1'b1;
                    x           <= sw_s;
                    press_count <= press_count + 4'd1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                HELD: if (!key_s) begin
                    state   <= FAST ? IDLE : RELEASE_DB;
                    readyin <= !FAST;
                end
                RELEASE_DB: if (key_s) begin
                    state <= HELD;
                end else if (cnt == LAST) begin
                    state   <= IDLE;
                    readyin <= 1'b0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap        <= '0;
            disp       <= '0;
            new_result <= 1'b0;
        end else begin
            cap        <= outport;
            new_result <= outport != cap;
            if (outport != cap) disp <= outport;
        end
    end
endmodule

// File: tb/tb_user_port.sv
// tb_user_port: table-driven and scoreboard checks of user_port with a short debounce interval.
module tb_user_port;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sw = '0;
    logic       key = 1'b0;
    logic [7:0] outport = '0;
    logic [7:0] x;
    logic       readyin;
    logic [7:0] disp;
    logic       new_result;
    logic [3:0] press_count;

    user_port #(.n(8), .DB_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .sw(sw), .key(key), .outport(outport),
        .x(x), .readyin(readyin), .disp(disp), .new_result(new_result),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [3:0] pc;
    } press_t;
    typedef struct {
        logic [7:0] op;
        logic       nr;
        logic [7:0] disp;
    } cap_vec_t;

    press_t     press_q[$];
    logic [7:0] cap_q[$];
    int         total = 0;
    int         bad = 0;
    int         nr_cnt = 0;
    logic       prev_rdy = 1'b0;
    logic [3:0] pc_m = '0;
    logic [7:0] op_m = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic drive_out(input logic [7:0] v);
        outport = v;
        if (v != op_m) cap_q.push_back(v);
        op_m = v;
    endtask

    task automatic expect_press(input logic [7:0] s);
        pc_m = pc_m + 4'd1;
        press_q.push_back('{s, pc_m});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_readyin"}, readyin, 0);
        chk({tag, "_disp"}, disp, 0);
        chk({tag, "_new_result"}, new_result, 0);
        chk({tag, "_press_count"}, press_count, 0);
    endtask

    always @(negedge clk) begin
        press_t pe;
        logic [7:0] ce;
        if (new_result) begin
            nr_cnt++;
            chk("cap_pending", cap_q.size() > 0, 1);
            if (cap_q.size() > 0) begin
                ce = cap_q.pop_front();
                chk("sb_disp", disp, ce);
            end
        end
        if (readyin && !prev_rdy) begin
            chk("press_pending", press_q.size() > 0, 1);
            if (press_q.size() > 0) begin
                pe = press_q.pop_front();
                chk("sb_x", x, pe.x);
                chk("sb_press_count", press_count, pe.pc);
            end
        end
        prev_rdy = readyin;
    end

    initial begin
        cap_vec_t   vec[5];
        int         rise, fall, nr0;
        logic       flag;
        logic [0:11] bpat;
        logic [0:5]  rpat;
        vec[0] = '{8'h00, 1'b0, 8'h00};
        vec[1] = '{8'h07, 1'b1, 8'h07};
        vec[2] = '{8'h07, 1'b0, 8'h07};
        vec[3] = '{8'h80, 1'b1, 8'h80};
        vec[4] = '{8'h80, 1'b0, 8'h80};

        step(3);
        chk_zero("reset");
        reset = 1'b0;
        step(2);

        // reset mid-hold, then re-debounce of a key still held
        sw = 8'hA5;
        expect_press(8'hA5);
        key = 1'b1;
        rise = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            if (readyin && rise == 0) rise = i;
        end
        chk("press_latency", rise, 6);
        chk("hold_x", x, 8'hA5);
        chk("hold_press_count", press_count, 1);
        #1 reset = 1'b1;
        #1 chk_zero("async_reset");
        step(2);
        reset = 1'b0;
        pc_m = '0;
        op_m = '0;
        expect_press(8'hA5);
        step(10);
        chk("redebounce_readyin", readyin, 1);
        key = 1'b0;
        step(8);
        chk("redebounce_release", readyin, 0);

        // press bounce
        sw = 8'h3C;
        bpat = 12'b110110000000;
        flag = 1'b0;
        for (int i = 0; i < 12; i++) begin
            key = bpat[i];
            step(1);
            flag |= readyin;
        end
        chk("bounce_readyin", flag, 0);
        chk("bounce_x", x, 8'hA5);
        chk("bounce_press_count", press_count, 1);

        // switches move while held and after release
        sw = 8'h11;
        expect_press(8'h11);
        key = 1'b1;
        step(8);
        sw = 8'hFF;
        step(4);
        chk("held_sw_x", x, 8'h11);
        key = 1'b0;
        step(8);
        chk("released_sw_x", x, 8'h11);
        chk("released_readyin", readyin, 0);
        expect_press(8'hFF);
        key = 1'b1;
        step(8);
        chk("next_press_x", x, 8'hFF);
        key = 1'b0;
        step(8);

        // release bounce
        sw = 8'h42;
        expect_press(8'h42);
        key = 1'b1;
        step(8);
        chk("rb_held", readyin, 1);
        rpat = 6'b001001;
        flag = 1'b1;
        for (int i = 0; i < 6; i++) begin
            key = rpat[i];
            step(1);
            flag &= readyin;
        end
        chk("rb_glitch_readyin", flag, 1);
        key = 1'b0;
        fall = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            if (!readyin && fall == 0) fall = i;
        end
        chk("release_latency", fall, 6);

        // output capture table
        nr0 = nr_cnt;
        for (int i = 0; i < 5; i++) begin
            drive_out(vec[i].op);
            step(1);
            chk($sformatf("cap_nr_%0d", i), new_result, vec[i].nr);
            chk($sformatf("cap_disp_%0d", i), disp, vec[i].disp);
        end
        @(negedge clk);
        chk("cap_strobes", nr_cnt - nr0, 2);
        step(1);

        // counter wrap, with a capture coinciding with one acceptance
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        pc_m = '0;
        op_m = '0;
        drive_out(outport);
        for (int i = 0; i < 17; i++) begin
            sw = 8'(i * 3 + 1);
            expect_press(sw);
            key = 1'b1;
            step(5);
            if (i == 8) drive_out(8'h5A);
            step(2);
            key = 1'b0;
            step(7);
        end
        chk("wrap_press_count", press_count, 1);
        chk("wrap_disp", disp, 8'h5A);
        chk("press_q_empty", press_q.size(), 0);
        chk("cap_q_empty", cap_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
